// File: rtl/buffer_ctrl_pkg.sv
// buffer_ctrl_pkg: shifter control codes, sequencer state encoding and shared helpers.
`default_nettype none

package buffer_ctrl_pkg;

  localparam logic [3:0] PAD_INIT_1   = 4'd0;
  localparam logic [3:0] PAD_INIT_2   = 4'd1;
  localparam logic [3:0] PAD_UINIT_1  = 4'd2;
  localparam logic [3:0] PAD_UINIT_2  = 4'd3;
  localparam logic [3:0] UPAD_INIT_1  = 4'd4;
  localparam logic [3:0] UPAD_INIT_2  = 4'd5;
  localparam logic [3:0] UPAD_UINIT_1 = 4'd6;
  localparam logic [3:0] UPAD_UINIT_2 = 4'd7;
  localparam logic [3:0] PAD_END_3    = 4'd8;
  localparam logic [3:0] PAD_END_4    = 4'd9;
  localparam logic [3:0] HOLD         = 4'd15;

  localparam logic [7:0] MUX_IDENTITY = 8'b11100100;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEAD    = 3'd1,
    S_BODY_LO = 3'd2,
    S_BODY_HI = 3'd3,
    S_END_3   = 3'd4,
    S_END_4   = 3'd5,
    S_FIN     = 3'd6
  } seq_state_t;

  // Shifter code issued by each slot-producing state; HOLD elsewhere.
  function automatic logic [3:0] slot_code(input seq_state_t s, input logic pad);
    case (s)
      S_HEAD:    return pad ? PAD_INIT_1  : UPAD_INIT_1;
      S_BODY_LO: return pad ? PAD_UINIT_1 : UPAD_UINIT_1;
      S_BODY_HI: return pad ? PAD_UINIT_2 : UPAD_UINIT_2;
      S_END_3:   return PAD_END_3;
      S_END_4:   return PAD_END_4;
      default:   return HOLD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/buffer_addr_gen.sv
// buffer_addr_gen: row/word counters and address accumulator for buffer_shift_seq.
`default_nettype none

module buffer_addr_gen
  import buffer_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              pad,
  input  logic              word_adv,
  input  logic              row_adv,
  input  logic [LEN_W-1:0]  row_words,
  input  logic [LEN_W-1:0]  num_rows,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] row_stride,
  output logic [ADDR_W-1:0] addr,
  output logic              last_word,
  output logic              last_row,
  output logic              zero_row
);

  logic [LEN_W-1:0]  words_q;
  logic [LEN_W-1:0]  rows_q;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] row_base_q;
  logic [LEN_W-1:0]  word_cnt_q;
  logic [LEN_W:0]    row_cnt_q;
  logic [LEN_W:0]    total_rows;
  logic              first_row;

  // Row counter spans the zero rows too, so it needs one extra bit.
  assign total_rows = {1'b0, rows_q} + (pad ? (LEN_W+1)'(2) : (LEN_W+1)'(0));
  assign first_row  = (row_cnt_q == '0);
  assign last_row   = ((row_cnt_q + (LEN_W+1)'(1)) == total_rows);
  assign last_word  = ((word_cnt_q + LEN_W'(1)) == words_q);
  assign zero_row   = pad && (first_row || last_row);
  assign addr       = row_base_q + ADDR_W'(word_cnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q    <= '0;
      rows_q     <= '0;
      stride_q   <= '0;
      row_base_q <= '0;
      word_cnt_q <= '0;
      row_cnt_q  <= '0;
    end else if (load) begin
      words_q    <= row_words;
      rows_q     <= num_rows;
      stride_q   <= row_stride;
      row_base_q <= base_addr;
      word_cnt_q <= '0;
      row_cnt_q  <= '0;
    end else if (row_adv) begin
      row_cnt_q  <= row_cnt_q + (LEN_W+1)'(1);
      word_cnt_q <= '0;
      // The leading zero row must not consume a stride step.
      if (!zero_row) begin
        row_base_q <= row_base_q + stride_q;
      end
    end else if (word_adv) begin
      word_cnt_q <= word_cnt_q + LEN_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/buffer_shift_seq.sv
// buffer_shift_seq: issues buffer-RAM reads and aligned shifter codes row by row,
// adding horizontal pad codes and vertical zero rows when pad is set.
`default_nettype none

module buffer_shift_seq
  import buffer_ctrl_pkg::*;
#(
  parameter int X_MAC      = 4,
  parameter int MUXCONTROL = 4,
  parameter int ADDR_W     = 10,
  parameter int LEN_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  pad,
  input  logic [LEN_W-1:0]      row_words,
  input  logic [LEN_W-1:0]      num_rows,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     row_stride,
  input  logic [X_MAC*2-1:0]    mux_cfg,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic [MUXCONTROL-1:0] control,
  output logic [X_MAC*2-1:0]    buffermux,
  output logic [X_MAC-1:0]      iszero,
  output logic                  busy,
  output logic                  done
);

  localparam int MW = X_MAC * 2;

  seq_state_t            state_q, state_d;
  logic                  pad_q;
  logic [MW-1:0]         mux_q;
  logic [MUXCONTROL-1:0] control_q;
  logic [X_MAC-1:0]      iszero_q;
  logic                  done_q;
  logic                  accept, empty_job;
  logic                  word_adv, row_adv, row_end, slot, rd_en_d;
  logic                  last_word, last_row, zero_row;

  assign accept    = start && (state_q == S_IDLE);
  assign empty_job = (row_words == '0) || (num_rows == '0);

  buffer_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .pad        (pad_q),
    .word_adv   (word_adv),
    .row_adv    (row_adv),
    .row_words  (row_words),
    .num_rows   (num_rows),
    .base_addr  (base_addr),
    .row_stride (row_stride),
    .addr       (rd_addr),
    .last_word  (last_word),
    .last_row   (last_row),
    .zero_row   (zero_row)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    word_adv = 1'b0;
    row_adv  = 1'b0;
    row_end  = 1'b0;
    slot     = 1'b0;
    rd_en_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && !empty_job) state_d = S_HEAD;
      end
      S_HEAD: begin
        slot    = 1'b1;
        rd_en_d = !zero_row;
        if (!last_word) begin
          state_d  = S_BODY_LO;
          word_adv = 1'b1;
        end else if (pad_q) begin
          state_d = S_END_3;
        end else begin
          row_end = 1'b1;
        end
      end
      S_BODY_LO: begin
        slot    = 1'b1;
        rd_en_d = !zero_row;
        state_d = S_BODY_HI;
      end
      S_BODY_HI: begin
        slot = 1'b1;
        if (!last_word) begin
          state_d  = S_BODY_LO;
          word_adv = 1'b1;
        end else if (pad_q) begin
          state_d = S_END_3;
        end else begin
          row_end = 1'b1;
        end
      end
      S_END_3: begin
        slot    = 1'b1;
        state_d = S_END_4;
      end
      S_END_4: begin
        slot    = 1'b1;
        row_end = 1'b1;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Next row's HEAD follows immediately; FIN only after the final row.
    if (row_end) begin
      if (last_row) begin
        state_d = S_FIN;
      end else begin
        state_d = S_HEAD;
        row_adv = 1'b1;
      end
    end
  end

  // Codes lag the read by one cycle so they meet the RAM data at the shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_q     <= 1'b0;
      mux_q     <= MW'(MUX_IDENTITY);
      control_q <= MUXCONTROL'(HOLD);
      iszero_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      if (accept) begin
        pad_q <= pad;
        mux_q <= mux_cfg;
      end
      control_q <= slot ? MUXCONTROL'(slot_code(state_q, pad_q)) : MUXCONTROL'(HOLD);
      iszero_q  <= (slot && zero_row) ? '1 : '0;
      done_q    <= (state_q == S_FIN) || (accept && empty_job);
    end
  end

  assign rd_en     = rd_en_d;
  assign control   = control_q;
  assign buffermux = mux_q;
  assign iszero    = iszero_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_buffer_shift_seq.sv
// tb_buffer_shift_seq: directed-vector bench with immediate assertions for buffer_shift_seq.
`default_nettype none

module tb_buffer_shift_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       pad;
  logic [7:0] row_words;
  logic [7:0] num_rows;
  logic [9:0] base_addr;
  logic [9:0] row_stride;
  logic [7:0] mux_cfg;
  logic       rd_en;
  logic [9:0] rd_addr;
  logic [3:0] control;
  logic [7:0] buffermux;
  logic [3:0] iszero;
  logic       busy;
  logic       done;

  int n_assert = 0;
  int n_fail   = 0;

  int exp_en   [0:63];
  int exp_addr [0:63];
  int exp_code [0:63];
  int exp_z    [0:63];

  buffer_shift_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pad        (pad),
    .row_words  (row_words),
    .num_rows   (num_rows),
    .base_addr  (base_addr),
    .row_stride (row_stride),
    .mux_cfg    (mux_cfg),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .control    (control),
    .buffermux  (buffermux),
    .iszero     (iszero),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int i, input int en, input int addr, input int code, input int z);
    exp_en[i]   = en;
    exp_addr[i] = addr;
    exp_code[i] = code;
    exp_z[i]    = z;
  endtask

  // Padded row of W=2: codes 0,2,3,8,9; a0<0 marks a zero row.
  task automatic pad_row_w2(input int i0, input int a0);
    if (a0 < 0) begin
      set_slot(i0+0, 0, -1, 0, 15);
      set_slot(i0+1, 0, -1, 2, 15);
      set_slot(i0+2, 0, -1, 3, 15);
      set_slot(i0+3, 0, -1, 8, 15);
      set_slot(i0+4, 0, -1, 9, 15);
    end else begin
      set_slot(i0+0, 1, a0,   0, 0);
      set_slot(i0+1, 1, a0+1, 2, 0);
      set_slot(i0+2, 0, a0+1, 3, 0);
      set_slot(i0+3, 0, -1,   8, 0);
      set_slot(i0+4, 0, -1,   9, 0);
    end
  endtask

  task automatic run_job(input string name, input logic p, input logic [7:0] w, input logic [7:0] r,
                         input logic [9:0] base, input logic [9:0] stride, input logic [7:0] mux,
                         input int n, input int restart_at);
    pad = p; row_words = w; num_rows = r; base_addr = base; row_stride = stride; mux_cfg = mux;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= n + 1; c++) begin
      if (c == restart_at) begin
        start = 1'b1; row_words = 8'd9; num_rows = 8'd5; mux_cfg = 8'hAA; base_addr = 10'h2AA;
      end else begin
        start = 1'b0;
      end
      if (c < n) begin
        chk($sformatf("%s rd_en s%0d", name, c), 32'(rd_en), 32'(exp_en[c]));
        if (exp_addr[c] >= 0)
          chk($sformatf("%s rd_addr s%0d", name, c), 32'(rd_addr), 32'(exp_addr[c]));
      end
      if (c <= n) begin
        chk($sformatf("%s busy c%0d", name, c), 32'(busy), 32'd1);
        chk($sformatf("%s done c%0d", name, c), 32'(done), 32'd0);
      end
      if (c == 0) begin
        chk($sformatf("%s control c0", name), 32'(control), 32'd15);
        chk($sformatf("%s buffermux c0", name), 32'(buffermux), 32'(mux));
      end else if (c <= n) begin
        chk($sformatf("%s control s%0d", name, c-1), 32'(control), 32'(exp_code[c-1]));
        chk($sformatf("%s iszero s%0d", name, c-1), 32'(iszero), 32'(exp_z[c-1]));
      end
      if (c == n) chk($sformatf("%s rd_en fin", name), 32'(rd_en), 32'd0);
      if (c == n + 1) begin
        chk($sformatf("%s done end", name), 32'(done), 32'd1);
        chk($sformatf("%s busy end", name), 32'(busy), 32'd0);
        chk($sformatf("%s control end", name), 32'(control), 32'd15);
        chk($sformatf("%s buffermux end", name), 32'(buffermux), 32'(mux));
      end
      tick();
    end
    start = 1'b0;
    chk($sformatf("%s done pulse", name), 32'(done), 32'd0);
  endtask

  task automatic load_t1(input int b);
    set_slot(0, 1, b,   4, 0);
    set_slot(1, 1, b+1, 6, 0);
    set_slot(2, 0, b+1, 7, 0);
    set_slot(3, 1, b+2, 6, 0);
    set_slot(4, 0, b+2, 7, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pad = 1'b0; row_words = '0; num_rows = '0;
    base_addr = '0; row_stride = '0; mux_cfg = '0;
    tick(); tick();
    chk("reset control", 32'(control), 32'd15);
    chk("reset rd_en", 32'(rd_en), 32'd0);
    chk("reset rd_addr", 32'(rd_addr), 32'd0);
    chk("reset iszero", 32'(iszero), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset buffermux", 32'(buffermux), 32'hE4);
    rst_n = 1'b1;
    tick();

    // pad=0, W=3, R=1; a start mid-job must be ignored
    load_t1(16);
    run_job("t1", 1'b0, 8'd3, 8'd1, 10'h010, 10'h000, 8'h1B, 5, 2);

    // pad=1, W=2, R=2, stride 8: zero, data@0, data@8, zero
    pad_row_w2(0, -1);
    pad_row_w2(5, 0);
    pad_row_w2(10, 8);
    pad_row_w2(15, -1);
    run_job("t2", 1'b1, 8'd2, 8'd2, 10'h000, 10'h008, 8'hE4, 20, -1);

    // address wrap, mux_cfg=0, ignored restart
    set_slot(0, 1, 'h3FE, 4, 0);
    set_slot(1, 1, 'h3FF, 6, 0);
    set_slot(2, 0, 'h3FF, 7, 0);
    set_slot(3, 1, 'h000, 6, 0);
    set_slot(4, 0, 'h000, 7, 0);
    set_slot(5, 1, 'h001, 6, 0);
    set_slot(6, 0, 'h001, 7, 0);
    run_job("wrap", 1'b0, 8'd4, 8'd1, 10'h3FE, 10'h000, 8'h00, 7, 4);

    // R=0: immediate done, no reads, no codes
    pad = 1'b1; row_words = 8'd3; num_rows = 8'd0; base_addr = 10'h055; mux_cfg = 8'hE4;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("r0 done", 32'(done), 32'd1);
    chk("r0 busy", 32'(busy), 32'd0);
    chk("r0 rd_en", 32'(rd_en), 32'd0);
    chk("r0 control", 32'(control), 32'd15);
    tick();
    chk("r0 done pulse", 32'(done), 32'd0);
    chk("r0 control after", 32'(control), 32'd15);
    chk("r0 rd_en after", 32'(rd_en), 32'd0);
    tick();

    // W=1, pad=1, R=1: codes 0,8,9 per row
    set_slot(0, 0, -1,   0, 15);
    set_slot(1, 0, -1,   8, 15);
    set_slot(2, 0, -1,   9, 15);
    set_slot(3, 1, 'h40, 0, 0);
    set_slot(4, 0, -1,   8, 0);
    set_slot(5, 0, -1,   9, 0);
    set_slot(6, 0, -1,   0, 15);
    set_slot(7, 0, -1,   8, 15);
    set_slot(8, 0, -1,   9, 15);
    run_job("w1pad", 1'b1, 8'd1, 8'd1, 10'h040, 10'h010, 8'hE4, 9, -1);

    // W=1, pad=0, R=2: single UPAD_INIT_1 per row, stride applied
    set_slot(0, 1, 'h100, 4, 0);
    set_slot(1, 1, 'h120, 4, 0);
    run_job("w1", 1'b0, 8'd1, 8'd2, 10'h100, 10'h020, 8'h39, 2, -1);

    // reset during BODY_HI aborts at once
    pad = 1'b0; row_words = 8'd3; num_rows = 8'd1; base_addr = 10'h020; row_stride = '0; mux_cfg = 8'h1B;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("rst pre control", 32'(control), 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst control", 32'(control), 32'd15);
    chk("rst rd_en", 32'(rd_en), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst iszero", 32'(iszero), 32'd0);
    chk("rst buffermux", 32'(buffermux), 32'hE4);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst done none", 32'(done), 32'd0);
    load_t1(32);
    run_job("after_rst", 1'b0, 8'd3, 8'd1, 10'h020, 10'h000, 8'h1B, 5, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
